// File: rtl/tartaruga_pkg.sv
// Shared types and constants for the tartaruga execute-stage units.
package tartaruga_pkg;

  typedef enum logic [1:0] {DIV_OP, DIVU_OP, REM_OP, REMU_OP} div_op_t;

  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_t;

  localparam int unsigned DIV_ITERS = 32;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;

endpackage

// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU; blocking, valid/ready handshake.
module div_unit
  import tartaruga_pkg::*;
(
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        valid_i,
  input  div_op_t     op_i,
  input  logic [31:0] data_rs1_i,
  input  logic [31:0] data_rs2_i,
  input  logic        kill_i,
  output logic        ready_o,
  output logic        valid_o,
  output logic [31:0] data_rd_o
);

  localparam logic [4:0] LAST_ITER = 5'(DIV_ITERS - 1);

  div_state_t  state_q, state_d;
  div_op_t     op_q, op_d;
  logic [31:0] dvd_q, dvd_d;   // dividend, shifts out while quotient bits shift in
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [31:0] data_rd_q, data_rd_d;
  logic        valid_q, valid_d;

  logic        is_signed;
  logic [63:0] step;
  logic [31:0] res_raw;
  logic        res_neg;

  // One restoring step: returns {next remainder, next dividend/quotient}.
  function automatic logic [63:0] div_step(logic [31:0] rem, logic [31:0] dvd, logic [31:0] dvs);
    logic [31:0] rem_sh;
    logic [32:0] diff;
    rem_sh = {rem[30:0], dvd[31]};
    diff   = {1'b0, rem_sh} - {1'b0, dvs};
    if (!diff[32]) return {diff[31:0], dvd[30:0], 1'b1};
    else           return {rem_sh, dvd[30:0], 1'b0};
  endfunction

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    data_rd_d = data_rd_q;
    valid_d   = 1'b0;

    is_signed = (op_i == DIV_OP) || (op_i == REM_OP);
    step      = div_step(rem_q, dvd_q, dvs_q);
    res_raw   = ((op_q == DIV_OP) || (op_q == DIVU_OP)) ? dvd_q : rem_q;
    res_neg   = ((op_q == DIV_OP) || (op_q == DIVU_OP)) ? neg_quo_q : neg_rem_q;

    unique case (state_q)
      DIV_IDLE: begin
        if (valid_i && !kill_i) begin
          op_d      = op_i;
          cnt_d     = 5'd0;
          rem_d     = 32'd0;
          dvd_d     = (is_signed && data_rs1_i[31]) ? -data_rs1_i : data_rs1_i;
          dvs_d     = (is_signed && data_rs2_i[31]) ? -data_rs2_i : data_rs2_i;
          neg_quo_d = is_signed && (data_rs1_i[31] ^ data_rs2_i[31]);
          neg_rem_d = is_signed && data_rs1_i[31];
          state_d   = DIV_CALC;
          // Special cases preload the final quotient/remainder and skip iteration.
          if (data_rs2_i == 32'd0) begin
            dvd_d     = 32'hFFFF_FFFF;
            rem_d     = data_rs1_i;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = DIV_DONE;
          end else if (is_signed && data_rs1_i == INT32_MIN && data_rs2_i == 32'hFFFF_FFFF) begin
            dvd_d     = INT32_MIN;
            rem_d     = 32'd0;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = DIV_DONE;
          end
        end
      end
      DIV_CALC: begin
        {rem_d, dvd_d} = step;
        cnt_d          = cnt_q + 5'd1;
        if (cnt_q == LAST_ITER) state_d = DIV_DONE;
      end
      DIV_DONE: begin
        data_rd_d = res_neg ? -res_raw : res_raw;
        valid_d   = 1'b1;
        state_d   = DIV_IDLE;
      end
      default: state_d = DIV_IDLE;
    endcase

    if (kill_i) begin
      state_d   = DIV_IDLE;
      valid_d   = 1'b0;
      data_rd_d = data_rd_q;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= DIV_IDLE;
      op_q      <= DIV_OP;
      dvd_q     <= 32'd0;
      dvs_q     <= 32'd0;
      rem_q     <= 32'd0;
      cnt_q     <= 5'd0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      data_rd_q <= 32'd0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      data_rd_q <= data_rd_d;
      valid_q   <= valid_d;
    end
  end

  assign ready_o   = (state_q == DIV_IDLE);
  assign valid_o   = valid_q;
  assign data_rd_o = data_rd_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit.
module tb_div_unit;
  import tartaruga_pkg::*;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        valid_i = 1'b0;
  div_op_t     op_i = DIVU_OP;
  logic [31:0] data_rs1_i = '0;
  logic [31:0] data_rs2_i = '0;
  logic        kill_i = 1'b0;
  logic        ready_o;
  logic        valid_o;
  logic [31:0] data_rd_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  div_unit dut (
    .clk_i      (clk_i),
    .rstn_i     (rstn_i),
    .valid_i    (valid_i),
    .op_i       (op_i),
    .data_rs1_i (data_rs1_i),
    .data_rs2_i (data_rs2_i),
    .kill_i     (kill_i),
    .ready_o    (ready_o),
    .valid_o    (valid_o),
    .data_rd_o  (data_rd_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one request and check result, latency, busy ready_o and the single-cycle pulse.
  task automatic do_op(input string tag, input div_op_t op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    logic busy_ok;
    lat = 0;
    @(negedge clk_i);
    while (!ready_o && lat < 60) begin
      @(negedge clk_i);
      lat++;
    end
    check({tag, "_ready_before"}, 32'(ready_o), 32'd1);
    valid_i = 1'b1; op_i = op; data_rs1_i = a; data_rs2_i = b;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!valid_o && lat < 60) begin
      if (ready_o) busy_ok = 1'b0;
      @(posedge clk_i); #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_data"}, data_rd_o, exp);
    check({tag, "_busy"}, 32'(busy_ok), 32'd1);
    @(posedge clk_i); #1;
    check({tag, "_pulse"}, 32'(valid_o), 32'd0);
  endtask

  initial begin
    int lat;
    int pulses;
    int t_prev;
    div_op_t s_op [3];
    logic [31:0] s_a [3];
    logic [31:0] s_b [3];
    logic [31:0] s_exp [3];

    #1;
    check("reset_ready", 32'(ready_o), 32'd1);
    check("reset_valid", 32'(valid_o), 32'd0);
    check("reset_data", data_rd_o, 32'd0);
    @(negedge clk_i); @(negedge clk_i);
    rstn_i = 1'b1;

    do_op("divu_100_7", DIVU_OP, 32'd100, 32'd7, 32'h0000_000E, 33);
    do_op("remu_100_7", REMU_OP, 32'd100, 32'd7, 32'h0000_0002, 33);
    do_op("div_m20_3", DIV_OP, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33);
    do_op("rem_m20_3", REM_OP, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33);
    do_op("div_20_m3", DIV_OP, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 33);
    do_op("rem_20_m3", REM_OP, 32'd20, 32'hFFFF_FFFD, 32'h0000_0002, 33);
    do_op("rem_5_0", REM_OP, 32'd5, 32'd0, 32'h0000_0005, 1);
    do_op("div_ovf", DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("rem_ovf", REM_OP, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
    do_op("divu_5_0", DIVU_OP, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);

    // Kill mid-iteration: no pulse, back to idle, previous result kept.
    @(negedge clk_i);
    valid_i = 1'b1; op_i = DIVU_OP; data_rs1_i = 32'd1000; data_rs2_i = 32'd3;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (10) @(posedge clk_i);
    @(negedge clk_i);
    kill_i = 1'b1;
    @(posedge clk_i); #1;
    kill_i = 1'b0;
    check("kill_ready", 32'(ready_o), 32'd1);
    check("kill_valid", 32'(valid_o), 32'd0);
    check("kill_data", data_rd_o, 32'hFFFF_FFFF);
    pulses = 0;
    repeat (40) begin
      @(posedge clk_i); #1;
      if (valid_o) pulses++;
    end
    check("kill_no_pulse", 32'(pulses), 32'd0);
    do_op("divu_9_2", DIVU_OP, 32'd9, 32'd2, 32'h0000_0004, 33);

    // Back-to-back with valid_i held high; junk operands shown while busy.
    s_op[0] = DIVU_OP; s_a[0] = 32'd100;        s_b[0] = 32'd7;          s_exp[0] = 32'h0000_000E;
    s_op[1] = REM_OP;  s_a[1] = 32'd20;         s_b[1] = 32'hFFFF_FFFD;  s_exp[1] = 32'h0000_0002;
    s_op[2] = DIV_OP;  s_a[2] = 32'hFFFF_FFEC;  s_b[2] = 32'd3;          s_exp[2] = 32'hFFFF_FFFA;
    t_prev = 0;
    @(negedge clk_i);
    valid_i = 1'b1; op_i = s_op[0]; data_rs1_i = s_a[0]; data_rs2_i = s_b[0];
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      op_i = DIVU_OP; data_rs1_i = 32'd1; data_rs2_i = 32'd1;
      lat = 0;
      while (!valid_o && lat < 60) begin
        @(posedge clk_i); #1;
        lat++;
      end
      check($sformatf("stream%0d_latency", i), 32'(lat), 32'd33);
      check($sformatf("stream%0d_data", i), data_rd_o, s_exp[i]);
      if (i > 0) check($sformatf("stream%0d_spacing", i), 32'(cyc - t_prev), 32'd34);
      t_prev = cyc;
      if (i < 2) begin
        op_i = s_op[i+1]; data_rs1_i = s_a[i+1]; data_rs2_i = s_b[i+1];
      end else begin
        valid_i = 1'b0;
      end
    end

    // Asynchronous reset in the middle of an operation.
    @(negedge clk_i);
    valid_i = 1'b1; op_i = DIVU_OP; data_rs1_i = 32'd1000; data_rs2_i = 32'd3;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #2;
    rstn_i = 1'b0;
    #1;
    check("arst_ready", 32'(ready_o), 32'd1);
    check("arst_valid", 32'(valid_o), 32'd0);
    check("arst_data", data_rd_o, 32'd0);
    @(negedge clk_i);
    rstn_i = 1'b1;
    do_op("divu_ffffffff_16", DIVU_OP, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 33);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
